adc0832_responder: RTL



---
 rtl/adc0832_pkg.sv | 54 +++++
 rtl/sync_edge.sv | 41 ++++
 rtl/adc0832_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/adc0832_pkg.sv
// ---------------------------------------------------------------------------
// adc0832_pkg
// Shared types and constants for the ADC0832 responder.
//   state_t      : responder sequence states
//   FALL_*       : serial falling-edge indices that mark phases of the DO frame
//   MUX_*        : {SGL,ODD} channel-select encodings
//   select_code  : picks the single-ended or saturated differential code
// ---------------------------------------------------------------------------
package adc0832_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        GET_SGL,
        GET_ODD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [4:0] FALL_NULL = 5'd0;
    localparam logic [4:0] FALL_MSB  = 5'd1;
    localparam logic [4:0] FALL_TAIL = 5'd9;
    localparam logic [4:0] FALL_END  = 5'd16;

    localparam logic [1:0] MUX_DIFF_CH0 = 2'b00;
    localparam logic [1:0] MUX_DIFF_CH1 = 2'b01;
    localparam logic [1:0] MUX_SE_CH0   = 2'b10;
    localparam logic [1:0] MUX_SE_CH1   = 2'b11;

    // Differential results are formed in 9 bits so a negative difference
    // shows up as a set borrow bit and can be clamped to zero.
    function automatic logic [7:0] select_code(input logic [1:0] mux,
                                               input logic [7:0] ch0,
                                               input logic [7:0] ch1);
        logic [8:0] diff;
        logic [7:0] result;
        diff   = 9'd0;
        result = 8'd0;
        case (mux)
            MUX_SE_CH0:   result = ch0;
            MUX_SE_CH1:   result = ch1;
            MUX_DIFF_CH0: begin
                diff   = {1'b0, ch0} - {1'b0, ch1};
                result = diff[8] ? 8'd0 : diff[7:0];
            end
            default: begin
                diff   = {1'b0, ch1} - {1'b0, ch0};
                result = diff[8] ? 8'd0 : diff[7:0];
            end
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Multi-flop synchronizer followed by a previous-level flop for edge detect.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   din       : asynchronous input
//   level     : synchronized level
//   rise/fall : one-clk pulses on synchronized level transitions
// RESET_VAL sets the idle level the chain and edge flop come out of reset at,
// so no spurious edge is reported on release.
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/adc0832_responder.sv
// ---------------------------------------------------------------------------
// adc0832_responder
// Serial-side emulation of an ADC0832: decodes start/SGL/ODD from the
// controller and shifts the selected (or differential) code out on D0832.
//   clk, rst            : system clock, asynchronous active-low reset
//   cs, clk_0832, DI    : controller chip select (low active), serial clock,
//                         serial command
//   ch0_code, ch1_code  : "analog" values presented by the fabric
//   D0832, do_oe        : serial data out and its output enable
//   busy                : start bit accepted and frame not yet finished
//   conv_valid          : one-clk pulse when the code is latched
//   conv_mux, conv_code : {SGL,ODD} and code of the latched conversion
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module adc0832_responder
    import adc0832_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       clk_0832,
    input  logic       DI,
    input  logic [7:0] ch0_code,
    input  logic [7:0] ch1_code,
    output logic       D0832,
    output logic       do_oe,
    output logic       busy,
    output logic       conv_valid,
    output logic [1:0] conv_mux,
    output logic [7:0] conv_code
);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic di_s, di_rise, di_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(clk_0832),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_di (
        .clk(clk), .rst(rst), .din(DI),
        .level(di_s), .rise(di_rise), .fall(di_fall)
    );

    // cs and DI are only used as levels.
    assign unused_edges = cs_rise ^ cs_fall ^ di_rise ^ di_fall;

    state_t     state, state_next;
    logic       sgl, sgl_next;
    logic [4:0] fall_cnt, fall_next;
    logic [7:0] code_next;
    logic [1:0] mux_next;
    logic       valid_next, dout_next, oe_next, busy_next;
    logic       shift_bit;
    logic [2:0] msb_idx;

    // Bit presented on the current falling edge. For F1..F8 the index is
    // 8-F, which in 3 bits is simply the negated low bits of F; for the
    // LSB-first tail F9..F15 the index is F-8, i.e. the low bits of F.
    always_comb begin
        shift_bit = 1'b0;
        msb_idx   = 3'd0 - fall_cnt[2:0];
        if (fall_cnt >= FALL_MSB && fall_cnt < FALL_TAIL) begin
            shift_bit = conv_code[msb_idx];
        end else if (fall_cnt >= FALL_TAIL && fall_cnt < FALL_END) begin
            shift_bit = conv_code[fall_cnt[2:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sgl        <= 1'b0;
            fall_cnt   <= FALL_NULL;
            conv_code  <= 8'd0;
            conv_mux   <= 2'b00;
            conv_valid <= 1'b0;
            D0832      <= 1'b0;
            do_oe      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            sgl        <= sgl_next;
            fall_cnt   <= fall_next;
            conv_code  <= code_next;
            conv_mux   <= mux_next;
            conv_valid <= valid_next;
            D0832      <= dout_next;
            do_oe      <= oe_next;
            busy       <= busy_next;
        end
    end

    // A high cs overrides everything so an abort always returns to IDLE.
    // In IDLE a serial clock that is already high when cs drops counts as
    // a rise, so controllers that park clk_0832 high still get their start
    // bit seen.
    always_comb begin
        state_next = state;
        sgl_next   = sgl;
        fall_next  = fall_cnt;
        code_next  = conv_code;
        mux_next   = conv_mux;
        valid_next = 1'b0;
        dout_next  = D0832;
        oe_next    = do_oe;
        busy_next  = busy;
        if (cs_s) begin
            state_next = IDLE;
            dout_next  = 1'b0;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
            fall_next  = FALL_NULL;
        end else begin
            case (state)
                IDLE: begin
                    state_next = WAIT_START;
                    if (sclk_s && di_s) begin
                        state_next = GET_SGL;
                        busy_next  = 1'b1;
                    end
                end
                WAIT_START: begin
                    if (sclk_rise && di_s) begin
                        state_next = GET_SGL;
                        busy_next  = 1'b1;
                    end
                end
                GET_SGL: begin
                    if (sclk_rise) begin
                        sgl_next   = di_s;
                        state_next = GET_ODD;
                    end
                end
                GET_ODD: begin
                    if (sclk_rise) begin
                        mux_next   = {sgl, di_s};
                        code_next  = select_code({sgl, di_s}, ch0_code, ch1_code);
                        valid_next = 1'b1;
                        fall_next  = FALL_NULL;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        oe_next   = 1'b1;
                        dout_next = shift_bit;
                        if (fall_cnt == FALL_END) begin
                            state_next = DONE;
                            busy_next  = 1'b0;
                        end else begin
                            fall_next = fall_cnt + 5'd1;
                        end
                    end
                end
                DONE: begin
                    oe_next   = 1'b1;
                    dout_next = 1'b0;
                    busy_next = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
